// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded operands and control from ID,
// detects load-use hazards against its own contents and inserts bubbles.
module id_ex_pipeline_reg #(
  parameter int N_BITS_DATA  = 32,
  parameter int N_BITS_REG   = 5,
  parameter int N_BITS_PC    = 32,
  parameter int N_BITS_ALUOP = 4,
  parameter int N_BITS_CNT   = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid_id,
  input  logic                    i_uses_rt_id,
  input  logic [N_BITS_REG-1:0]   i_rs_id,
  input  logic [N_BITS_REG-1:0]   i_rt_id,
  input  logic [N_BITS_REG-1:0]   i_rd_id,
  input  logic [N_BITS_DATA-1:0]  i_data_rs_id,
  input  logic [N_BITS_DATA-1:0]  i_data_rt_id,
  input  logic [N_BITS_DATA-1:0]  i_imm_id,
  input  logic [N_BITS_PC-1:0]    i_pc_id,
  input  logic                    i_regWrite_id,
  input  logic                    i_memRead_id,
  input  logic                    i_memWrite_id,
  input  logic                    i_memToReg_id,
  input  logic                    i_regDst_id,
  input  logic                    i_aluSrc_id,
  input  logic [N_BITS_ALUOP-1:0] i_aluOp_id,
  input  logic                    i_flush,
  input  logic                    i_halt,
  output logic [N_BITS_REG-1:0]   o_rs,
  output logic [N_BITS_REG-1:0]   o_rt,
  output logic [N_BITS_REG-1:0]   o_rd,
  output logic [N_BITS_DATA-1:0]  o_data_rs,
  output logic [N_BITS_DATA-1:0]  o_data_rt,
  output logic [N_BITS_DATA-1:0]  o_imm,
  output logic [N_BITS_PC-1:0]    o_pc,
  output logic                    o_regWrite,
  output logic                    o_memRead,
  output logic                    o_memWrite,
  output logic                    o_memToReg,
  output logic                    o_regDst,
  output logic                    o_aluSrc,
  output logic [N_BITS_ALUOP-1:0] o_aluOp,
  output logic                    o_valid,
  output logic                    o_stall,
  output logic [N_BITS_CNT-1:0]   o_bubble_count
);

  localparam int CTRL_W = 6;
  localparam int CTRL_MEM_READ = 4;
  localparam logic [N_BITS_CNT-1:0] CNT_MAX = '1;
  localparam logic [N_BITS_CNT-1:0] CNT_ONE = N_BITS_CNT'(1);

  logic [N_BITS_REG-1:0]   rs_reg, rt_reg, rd_reg;
  logic [N_BITS_DATA-1:0]  data_rs_reg, data_rt_reg, imm_reg;
  logic [N_BITS_PC-1:0]    pc_reg;
  logic [CTRL_W-1:0]       ctrl_reg;
  logic [CTRL_W-1:0]       ctrl_id;
  logic [N_BITS_ALUOP-1:0] alu_op_reg;
  logic                    valid_reg;
  logic [N_BITS_CNT-1:0]   cnt_reg, cnt_next;
  logic                    hazard;

  // Control bit order: regWrite, memRead, memWrite, memToReg, regDst, aluSrc
  assign ctrl_id = {i_regWrite_id, i_memRead_id, i_memWrite_id,
                    i_memToReg_id, i_regDst_id, i_aluSrc_id};

  // A load to $0 never produces a value worth waiting for
  assign hazard = valid_reg & ctrl_reg[CTRL_MEM_READ] & (rt_reg != '0) & i_valid_id &
                  ((rt_reg == i_rs_id) | (i_uses_rt_id & (rt_reg == i_rt_id)));

  always_comb begin
    cnt_next = cnt_reg;
    if (hazard && !i_flush && (cnt_reg != CNT_MAX))
      cnt_next = cnt_reg + CNT_ONE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rs_reg      <= '0;
      rt_reg      <= '0;
      rd_reg      <= '0;
      data_rs_reg <= '0;
      data_rt_reg <= '0;
      imm_reg     <= '0;
      pc_reg      <= '0;
      ctrl_reg    <= '0;
      alu_op_reg  <= '0;
      valid_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else if (!i_halt) begin
      cnt_reg <= cnt_next;
      if (i_flush || hazard) begin
        // Bubble: zeroed indices keep the forwarding unit from matching it
        rs_reg      <= '0;
        rt_reg      <= '0;
        rd_reg      <= '0;
        data_rs_reg <= '0;
        data_rt_reg <= '0;
        imm_reg     <= '0;
        pc_reg      <= '0;
        ctrl_reg    <= '0;
        alu_op_reg  <= '0;
        valid_reg   <= 1'b0;
      end else begin
        rs_reg      <= i_rs_id;
        rt_reg      <= i_rt_id;
        rd_reg      <= i_rd_id;
        data_rs_reg <= i_data_rs_id;
        data_rt_reg <= i_data_rt_id;
        imm_reg     <= i_imm_id;
        pc_reg      <= i_pc_id;
        ctrl_reg    <= ctrl_id;
        alu_op_reg  <= i_aluOp_id;
        valid_reg   <= i_valid_id;
      end
    end
  end

  assign o_rs           = rs_reg;
  assign o_rt           = rt_reg;
  assign o_rd           = rd_reg;
  assign o_data_rs      = data_rs_reg;
  assign o_data_rt      = data_rt_reg;
  assign o_imm          = imm_reg;
  assign o_pc           = pc_reg;
  assign o_regWrite     = ctrl_reg[5];
  assign o_memRead      = ctrl_reg[4];
  assign o_memWrite     = ctrl_reg[3];
  assign o_memToReg     = ctrl_reg[2];
  assign o_regDst       = ctrl_reg[1];
  assign o_aluSrc       = ctrl_reg[0];
  assign o_aluOp        = alu_op_reg;
  assign o_valid        = valid_reg;
  assign o_stall        = hazard;
  assign o_bubble_count = cnt_reg;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized and directed bench for id_ex_pipeline_reg against a
// field-level reference model of the pipeline register.
module tb_id_ex_pipeline_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int PW = 32;
  localparam int AW = 4;
  localparam int CW = 5;  // narrow counter so saturation is reachable quickly
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs, rt, rd;
    logic [DW-1:0] data_rs, data_rt, imm;
    logic [PW-1:0] pc;
    logic          reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
    logic [AW-1:0] alu_op;
  } ex_t;

  typedef struct packed {
    ex_t  f;
    logic uses_rt;
  } id_t;

  logic i_clock = 1'b0;
  logic i_reset;
  logic flush, halt;
  id_t  id;

  logic [RW-1:0] o_rs, o_rt, o_rd;
  logic [DW-1:0] o_data_rs, o_data_rt, o_imm;
  logic [PW-1:0] o_pc;
  logic          o_regWrite, o_memRead, o_memWrite, o_memToReg, o_regDst, o_aluSrc;
  logic [AW-1:0] o_aluOp;
  logic          o_valid, o_stall;
  logic [CW-1:0] o_bubble_count;
  ex_t           dut_ex;

  ex_t m;
  int  m_cnt;
  int  total = 0;
  int  bad = 0;
  int  n_step = 0;

  always #5 i_clock = ~i_clock;

  id_ex_pipeline_reg #(
    .N_BITS_DATA(DW), .N_BITS_REG(RW), .N_BITS_PC(PW),
    .N_BITS_ALUOP(AW), .N_BITS_CNT(CW)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_valid_id(id.f.valid), .i_uses_rt_id(id.uses_rt),
    .i_rs_id(id.f.rs), .i_rt_id(id.f.rt), .i_rd_id(id.f.rd),
    .i_data_rs_id(id.f.data_rs), .i_data_rt_id(id.f.data_rt),
    .i_imm_id(id.f.imm), .i_pc_id(id.f.pc),
    .i_regWrite_id(id.f.reg_write), .i_memRead_id(id.f.mem_read),
    .i_memWrite_id(id.f.mem_write), .i_memToReg_id(id.f.mem_to_reg),
    .i_regDst_id(id.f.reg_dst), .i_aluSrc_id(id.f.alu_src),
    .i_aluOp_id(id.f.alu_op), .i_flush(flush), .i_halt(halt),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_data_rs(o_data_rs), .o_data_rt(o_data_rt), .o_imm(o_imm), .o_pc(o_pc),
    .o_regWrite(o_regWrite), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_memToReg(o_memToReg), .o_regDst(o_regDst), .o_aluSrc(o_aluSrc),
    .o_aluOp(o_aluOp), .o_valid(o_valid), .o_stall(o_stall),
    .o_bubble_count(o_bubble_count)
  );

  always_comb begin
    dut_ex            = '0;
    dut_ex.valid      = o_valid;
    dut_ex.rs         = o_rs;
    dut_ex.rt         = o_rt;
    dut_ex.rd         = o_rd;
    dut_ex.data_rs    = o_data_rs;
    dut_ex.data_rt    = o_data_rt;
    dut_ex.imm        = o_imm;
    dut_ex.pc         = o_pc;
    dut_ex.reg_write  = o_regWrite;
    dut_ex.mem_read   = o_memRead;
    dut_ex.mem_write  = o_memWrite;
    dut_ex.mem_to_reg = o_memToReg;
    dut_ex.reg_dst    = o_regDst;
    dut_ex.alu_src    = o_aluSrc;
    dut_ex.alu_op     = o_aluOp;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A load in EX stalls a valid ID instruction that reads its destination
  function automatic logic model_stall(input ex_t ex, input id_t d);
    return ex.valid && ex.mem_read && (ex.rt != 0) && d.f.valid &&
           ((ex.rt == d.f.rs) || (d.uses_rt && (ex.rt == d.f.rt)));
  endfunction

  task automatic step(input string tag);
    logic s;
    #1;
    s = model_stall(m, id);
    check({tag, ".stall"}, 256'(o_stall), 256'(s));
    @(posedge i_clock);
    if (!halt) begin
      if (flush) m = '0;
      else if (s) begin
        m = '0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else m = id.f;
    end
    #1;
    check({tag, ".ex"}, 256'(dut_ex), 256'(m));
    check({tag, ".cnt"}, 256'(o_bubble_count), 256'(m_cnt));
    n_step++;
    $display("step %0d %s: flush=%0b halt=%0b stall=%0b valid=%0b cnt=%0d",
             n_step, tag, flush, halt, s, o_valid, o_bubble_count);
  endtask

  function automatic id_t load_id(input int rt);
    id_t d = '0;
    d.f.valid = 1'b1;
    d.f.rs = RW'($urandom_range(1, 31));
    d.f.rt = RW'(rt);
    d.f.imm = $urandom;
    d.f.pc = $urandom;
    d.f.data_rs = $urandom;
    d.f.reg_write = 1'b1;
    d.f.mem_read = 1'b1;
    d.f.mem_to_reg = 1'b1;
    d.f.alu_src = 1'b1;
    return d;
  endfunction

  function automatic id_t use_id(input int rs, input int rt, input logic uses_rt);
    id_t d = '0;
    d.f.valid = 1'b1;
    d.uses_rt = uses_rt;
    d.f.rs = RW'(rs);
    d.f.rt = RW'(rt);
    d.f.rd = RW'($urandom_range(1, 31));
    d.f.data_rs = $urandom;
    d.f.data_rt = $urandom;
    d.f.pc = $urandom;
    d.f.reg_write = 1'b1;
    d.f.reg_dst = 1'b1;
    d.f.alu_op = AW'($urandom_range(0, 15));
    return d;
  endfunction

  function automatic id_t rand_id();
    id_t d;
    d.f.valid = ($urandom_range(0, 3) != 0);
    d.uses_rt = 1'($urandom_range(0, 1));
    d.f.rs = RW'($urandom_range(0, 3));
    d.f.rt = RW'($urandom_range(0, 3));
    d.f.rd = RW'($urandom_range(0, 31));
    d.f.data_rs = $urandom;
    d.f.data_rt = $urandom;
    d.f.imm = $urandom;
    d.f.pc = $urandom;
    d.f.reg_write = 1'($urandom_range(0, 1));
    d.f.mem_read = 1'($urandom_range(0, 1));
    d.f.mem_write = 1'($urandom_range(0, 1));
    d.f.mem_to_reg = 1'($urandom_range(0, 1));
    d.f.reg_dst = 1'($urandom_range(0, 1));
    d.f.alu_src = 1'($urandom_range(0, 1));
    d.f.alu_op = AW'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    i_reset = 1'b1;
    flush = 1'b0;
    halt = 1'b0;
    id = '0;
    m = '0;
    m_cnt = 0;
    @(posedge i_clock);
    #1;
    check("reset.ex", 256'(dut_ex), 256'(0));
    check("reset.cnt", 256'(o_bubble_count), 256'(0));
    check("reset.stall", 256'(o_stall), 256'(0));
    i_reset = 1'b0;

    // Pass-through
    id = '0;
    id.f.valid = 1'b1;
    id.f.rs = 5'd3;
    id.f.rt = 5'd4;
    id.f.rd = 5'd5;
    id.f.data_rs = 32'h11;
    id.f.alu_op = 4'd2;
    id.f.reg_write = 1'b1;
    step("pass");
    check("pass.rs", 256'(o_rs), 256'(3));
    check("pass.rd", 256'(o_rd), 256'(5));
    check("pass.data_rs", 256'(o_data_rs), 256'(32'h11));
    check("pass.valid", 256'(o_valid), 256'(1));

    // Load-use on rs: one bubble, then the dependent instruction is captured
    id = load_id(8);
    step("lu.load");
    id = use_id(8, 2, 1'b1);
    step("lu.bubble");
    check("lu.cnt1", 256'(o_bubble_count), 256'(1));
    check("lu.bubble_valid", 256'(o_valid), 256'(0));
    step("lu.capture");
    check("lu.captured_rs", 256'(o_rs), 256'(8));

    // rt match that is not a source, and a load to $0
    id = load_id(8);
    step("nort.load");
    id = use_id(1, 8, 1'b0);
    step("nort.use");
    id = load_id(0);
    step("zero.load");
    id = use_id(0, 0, 1'b1);
    step("zero.use");

    // Flush and stall together: bubble without counting
    id = load_id(9);
    step("fs.load");
    id = use_id(9, 9, 1'b1);
    flush = 1'b1;
    step("fs.both");
    flush = 1'b0;
    check("fs.cnt", 256'(o_bubble_count), 256'(1));

    // Halt during a stall: everything frozen, stall held until halt drops
    id = load_id(10);
    step("halt.load");
    id = use_id(3, 10, 1'b1);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) step("halt.hold");
    check("halt.stall_held", 256'(o_stall), 256'(1));
    halt = 1'b0;
    step("halt.bubble");
    step("halt.capture");

    // Random traffic with occasional flush and halt
    for (int i = 0; i < 300; i++) begin
      id = rand_id();
      flush = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    flush = 1'b0;
    halt = 1'b0;

    // Asynchronous reset mid-cycle with a load held and a nonzero counter
    id = load_id(7);
    step("ar.load");
    id = use_id(7, 0, 1'b0);
    #2;
    i_reset = 1'b1;
    #1;
    m = '0;
    m_cnt = 0;
    check("ar.ex", 256'(dut_ex), 256'(0));
    check("ar.cnt", 256'(o_bubble_count), 256'(0));
    check("ar.stall", 256'(o_stall), 256'(0));
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    check("ar.held", 256'(dut_ex), 256'(0));

    // Saturation: more load-use pairs than the counter can hold
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      id = load_id(($urandom_range(0, 30)) + 1);
      step("sat.load");
      id = use_id(int'(id.f.rt), 0, 1'b0);
      step("sat.bubble");
      step("sat.capture");
    end
    check("sat.max", 256'(o_bubble_count), 256'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures decoded operands, register indices and EX/MEM/WB control from the ID stage each cycle.
- Drives the rs/rt indices consumed by the forwarding unit and the ALU operand muxes in EX.
- Detects load-use hazards against its own contents, requests an upstream stall, and inserts a bubble; also honours branch flush and debug halt.

Parameters:
- N_BITS_DATA, 32, width of register-file data and sign-extended immediate
- N_BITS_REG, 5, width of a register index
- N_BITS_PC, 32, width of the program counter
- N_BITS_ALUOP, 4, width of the ALU operation code
- N_BITS_CNT, 16, width of the bubble counter

Ports:
- i_clock  input  1  system clock; all state updates on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_valid_id  input  1  IF/ID holds a real instruction
- i_uses_rt_id  input  1  ID instruction reads rt as a source (R-type, store, branch)
- i_rs_id  input  N_BITS_REG  ID source index rs
- i_rt_id  input  N_BITS_REG  ID source index rt
- i_rd_id  input  N_BITS_REG  ID destination index rd
- i_data_rs_id  input  N_BITS_DATA  register-file read data rs
- i_data_rt_id  input  N_BITS_DATA  register-file read data rt
- i_imm_id  input  N_BITS_DATA  sign-extended immediate
- i_pc_id  input  N_BITS_PC  PC+4 of ID instruction
- i_regWrite_id, i_memRead_id, i_memWrite_id, i_memToReg_id, i_regDst_id, i_aluSrc_id  input  1 each  control bits
- i_aluOp_id  input  N_BITS_ALUOP  ALU operation
- i_flush  input  1  branch/jump resolved taken; squash ID instruction
- i_halt  input  1  debug-unit step disable; freeze register
- o_rs, o_rt, o_rd  output  N_BITS_REG  registered indices to EX and forwarding unit
- o_data_rs, o_data_rt, o_imm  output  N_BITS_DATA  registered operands
- o_pc  output  N_BITS_PC  registered PC+4
- o_regWrite, o_memRead, o_memWrite, o_memToReg, o_regDst, o_aluSrc  output  1 each  registered control
- o_aluOp  output  N_BITS_ALUOP  registered ALU operation
- o_valid  output  1  EX stage holds a real instruction
- o_stall  output  1  combinational load-use stall request to PC and IF/ID
- o_bubble_count  output  N_BITS_CNT  saturating count of bubbles inserted

Behaviour:
- Reset (async, any time, including mid-stall): all registered outputs 0; o_valid=0; o_bubble_count=0. o_stall then evaluates to 0 because o_memRead=0.
- Hazard, combinational: o_stall = o_valid & o_memRead & (o_rt != 0) & i_valid_id & ((o_rt == i_rs_id) | (i_uses_rt_id & (o_rt == i_rt_id))).
- Per-edge update priority, highest first:
  1. i_halt=1: hold every register and the counter unchanged. o_stall is still driven from current contents.
  2. i_flush=1: load bubble (see below). Counter does not increment.
  3. o_stall=1: load bubble; counter increments by 1, saturating at all-ones.
  4. Otherwise: capture all i_*_id fields; o_valid <= i_valid_id.
- Bubble definition:
  - o_regWrite, o_memRead, o_memWrite, o_memToReg, o_regDst, o_aluSrc = 0; o_aluOp = 0; o_valid = 0.
  - o_rs, o_rt, o_rd = 0, so the forwarding unit never matches a bubble.
  - Data fields and o_pc = 0.
- Latency: exactly one cycle from ID inputs to outputs.
- Stall duration: at most one cycle per load, because the bubble clears o_memRead. Upstream holds IF/ID while o_stall=1, so the same instruction is presented again and captured on the following edge.
- Simultaneous flush and stall: flush wins, and the counter is unchanged.
- Load to $0: never stalls.
- Invalid ID instruction (i_valid_id=0): never stalls; captured with o_valid=0 and its control fields as given.

Test Plan:
- Reset: assert i_reset mid-cycle with registers loaded -> all outputs 0 immediately (before next edge); o_bubble_count=0; o_stall=0.
- Pass-through: i_rs_id=3, i_rt_id=4, i_rd_id=5, i_data_rs_id=0x11, i_aluOp_id=2, i_regWrite_id=1, i_valid_id=1 -> after one edge o_rs=3, o_rt=4, o_rd=5, o_data_rs=0x11, o_aluOp=2, o_regWrite=1, o_valid=1, o_stall=0.
- Load-use rs: load rt=8 (memRead=1) in ID/EX, ID has rs=8 -> o_stall=1; next edge gives all control 0, o_valid=0, o_bubble_count=1; o_stall=0 after; the following edge captures the dependent instruction.
- rt match with i_uses_rt_id=0, or load rt=0 matching rs=0 -> o_stall=0, normal capture, counter unchanged.
- Flush and stall in the same cycle -> bubble loaded, o_bubble_count unchanged. Separately, i_halt=1 during a stall -> outputs and counter frozen for every halted cycle; o_stall stays 1 until halt drops and the bubble is inserted.
- Saturation: preload 0xFFFE via repeated stalls (or force), then trigger two more stalls -> counter reads 0xFFFF and stays 0xFFFF.
